fetch_stage: RTL
================

Name: fetch_stage

Overview:
- Instruction fetch stage sitting directly upstream of the decoder/register-file stage.
- Owns the PC, issues word reads to a synchronous instruction memory (1-cycle read latency), and presents instr/instr_pc/instr_valid to decode.
- Honours a decode stall (backpressure) through a 1-entry skid buffer, so no fetched word is lost or duplicated.
- Accepts a branch/jump redirect that flushes all in-flight and buffered fetches.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0013, value driven on instr when not valid (addi x0,x0,0).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- imem_addr  out  32  byte address of the fetch; equals pc; bits [1:0] always 0.
- imem_req  out  1  read request; memory samples imem_addr at the rising edge where imem_req=1.
- imem_rdata  in  32  read data, valid during the cycle after the request edge.
- stall  in  1  decode not ready; the current output is held.
- redirect_valid  in  1  control-flow change request.
- redirect_pc  in  32  target address; bits [1:0] ignored and treated as 0.
- instr  out  32  instruction to decode.
- instr_pc  out  32  PC of instr.
- instr_valid  out  1  instr/instr_pc are meaningful.

Behaviour:
- Reset (async, immediate):
  - pc=RESET_PC.
  - instr_valid=0, instr=NOP_INSTR, instr_pc=0.
  - pending=0, skid_valid=0.
  - imem_req=0 while rst is high.
- State:
  - pc.
  - pending flag plus pend_pc, marking a request issued last edge.
  - Output register: instr_valid, instr, instr_pc.
  - Skid register: skid_valid, skid_instr, skid_pc.
- imem_req (combinational) = !rst && !redirect_valid && !skid_valid && !(stall && instr_valid && pending).
  - A request is issued only when a slot is guaranteed for its response.
- On an edge with imem_req=1: pending<=1, pend_pc<=pc, pc<=pc+4. The add wraps modulo 2^32 (32'hFFFF_FFFC -> 0).
- On an edge with imem_req=0 and no redirect: pending<=0, pc unchanged.
- Consume: the output is consumed at an edge where instr_valid && !stall.
- Output register fill priority, evaluated at each edge:
  1. skid_valid and output consumed/empty: skid moves to the output, skid_valid<=0.
  2. Otherwise pending and output consumed/empty: imem_rdata/pend_pc go to the output.
  3. Otherwise pending and output held (stall): response goes to the skid, skid_valid<=1.
  4. If nothing fills an empty or consumed output: instr_valid<=0, instr<=NOP_INSTR.
- Skid drain cycle: when the skid drains, imem_req was 0 that cycle, so no new response competes. This creates one bubble per stall episode, which is accepted.
- Steady state without stall: one instruction per cycle, first instr_valid 2 cycles after rst deasserts (edge 1 issues, edge 2 captures).
- Redirect (synchronous, highest priority, wins over stall and any response):
  - pc<=redirect_pc & ~3.
  - pending<=0; the arriving imem_rdata is discarded.
  - skid_valid<=0, instr_valid<=0, instr<=NOP_INSTR.
  - The next cycle issues a fetch at the target; its instruction is valid 2 edges after the redirect edge.
- While stall=1: instr, instr_pc and instr_valid are held stable; no instruction is dropped or repeated.
- Reset asserted mid-stream: all state clears immediately; the first fetch after release is at RESET_PC.

Test Plan:
- Reset and stream: memory word[i] = 32'h1000_0000+i, release rst. instr_pc sequence 0,4,8,12 on consecutive cycles, instr = 32'h1000_0000..03, first valid 2 cycles after release.
- Stall: assert stall for 3 cycles while instr_pc=8 is valid. instr_pc holds at 8. After release, the sequence continues 12,16,... with no gap other than at most one bubble, no duplicate, no loss.
- Redirect: pulse redirect_valid with redirect_pc=32'h40 while instr_pc=4. instr_valid=0 the next cycle. The next valid instr_pc is 32'h40, then 32'h44. Words 8/12 never appear.
- Redirect during stall with skid full: stall=1, skid occupied, redirect to 32'h80. Skid flushed; the next valid instr_pc is 32'h80 once stall drops, even if stall stays high at the redirect.
- Wrap and alignment: redirect_pc=32'hFFFF_FFFE gives instr_pc FFFF_FFFC then 0000_0000. imem_addr[1:0]=0 throughout.
- Async reset mid-stream: assert rst between clock edges while instr_valid=1. instr_valid=0 and instr=32'h13 without waiting for a clock edge. After release, the first instr_pc=RESET_PC.

Source files
------------

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage with PC, 1-entry skid buffer and redirect flush
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    output logic        imem_req,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        instr_valid
);

    logic [31:0] pc;
    logic        pending;
    logic [31:0] pend_pc;
    logic        skid_valid;
    logic [31:0] skid_instr;
    logic [31:0] skid_pc;
    logic        out_free;

    // Only request when the response is guaranteed a landing slot next edge.
    assign imem_req  = !rst && !redirect_valid && !skid_valid && !(stall && instr_valid && pending);
    assign imem_addr = pc;
    assign out_free  = !instr_valid || !stall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc          <= RESET_PC & ~32'h3;
            pending     <= 1'b0;
            pend_pc     <= 32'h0;
            skid_valid  <= 1'b0;
            skid_instr  <= NOP_INSTR;
            skid_pc     <= 32'h0;
            instr_valid <= 1'b0;
            instr       <= NOP_INSTR;
            instr_pc    <= 32'h0;
        end else if (redirect_valid) begin
            pc          <= redirect_pc & ~32'h3;
            pending     <= 1'b0;
            skid_valid  <= 1'b0;
            instr_valid <= 1'b0;
            instr       <= NOP_INSTR;
        end else begin
            if (imem_req) begin
                pending <= 1'b1;
                pend_pc <= pc;
                pc      <= pc + 32'd4;
            end else begin
                pending <= 1'b0;
            end

            if (skid_valid && out_free) begin
                instr_valid <= 1'b1;
                instr       <= skid_instr;
                instr_pc    <= skid_pc;
                skid_valid  <= 1'b0;
            end else if (pending && out_free) begin
                instr_valid <= 1'b1;
                instr       <= imem_rdata;
                instr_pc    <= pend_pc;
            end else if (pending) begin
                // Output is held by stall: park the arriving word.
                skid_valid <= 1'b1;
                skid_instr <= imem_rdata;
                skid_pc    <= pend_pc;
            end else if (out_free) begin
                instr_valid <= 1'b0;
                instr       <= NOP_INSTR;
            end
        end
    end

endmodule
